// File: rtl/ofmap_writer.sv
// Output-feature-map writer: requantizes one or two row lanes per beat,
// queues {addr, data} entries and drains them to the output SRAM.
module ofmap_writer #(
    parameter int DATA_W     = 25,
    parameter int OUT_W      = 8,
    parameter int SHIFT      = 8,
    parameter int ROW_LEN    = 61,
    parameter int NUM_ROWS   = 61,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] in0,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in1,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [OUT_W-1:0]  mem_wr_data,
    input  logic              mem_ready,
    output logic              frame_done,
    output logic              overflow,
    output logic              proto_err
);
    localparam int SW = DATA_W + 2;
    localparam int CW = $clog2(ROW_LEN);
    localparam int RW = $clog2(NUM_ROWS + 2);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ADDR_W + OUT_W;
    localparam logic signed [SW-1:0] RND  = SW'(2 ** (SHIFT - 1));
    localparam logic signed [SW-1:0] UMAX = SW'(2 ** OUT_W - 1);
    localparam logic signed [SW-1:0] SMAX = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_t;

    function automatic logic [OUT_W-1:0] requant(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] b,
        input logic              relu
    );
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] q;
        s = $signed({{2{x[DATA_W-1]}}, x}) + $signed({{2{b[DATA_W-1]}}, b});
        if (relu && s < 0) s = '0;
        q = (s + RND) >>> SHIFT;
        if (relu) begin
            if (q > UMAX) q = UMAX;
        end else if (q > SMAX) begin
            q = SMAX;
        end else if (q < SMIN) begin
            q = SMIN;
        end
        return q[OUT_W-1:0];
    endfunction

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row_base;
    logic [RW-1:0]     nb;
    logic              accept;
    logic              last_col;
    logic [ADDR_W-1:0] a0;

    logic              s1_v0, s1_v1;
    logic [ADDR_W-1:0] s1_a0, s1_a1;
    logic [OUT_W-1:0]  s1_d0, s1_d1;

    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       cnt, total, free;
    logic              pop, acc0, acc1, drop;
    logic              take, from_fifo, bypass, push0, push1, drained;

    assign accept   = in0_valid && state == ACTIVE;
    assign last_col = col == CW'(ROW_LEN - 1);
    assign nb       = row_base + (in1_valid ? RW'(2) : RW'(1));
    assign a0       = ADDR_W'(row_base) * ADDR_W'(ROW_LEN) + ADDR_W'(col);

    // The output register counts as a slot, so FIFO_DEPTH entries are retained in total.
    assign pop       = mem_wr_en && mem_ready;
    assign total     = cnt + (PW+1)'(mem_wr_en);
    assign free      = (PW+1)'(FIFO_DEPTH) - total + (PW+1)'(pop);
    assign acc0      = s1_v0 && free >= (PW+1)'(1);
    assign acc1      = s1_v1 && free >= (PW+1)'(2);
    assign drop      = (s1_v0 && !acc0) || (s1_v1 && !acc1);
    assign take      = !mem_wr_en || pop;
    assign from_fifo = take && cnt != '0;
    assign bypass    = take && cnt == '0 && acc0;
    assign push0     = acc0 && !bypass;
    assign push1     = acc1;
    assign drained   = !s1_v0 && cnt == '0 && (!mem_wr_en || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACTIVE;
            col        <= '0;
            row_base   <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            state      <= ACTIVE;
            col        <= '0;
            row_base   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ACTIVE: if (accept) begin
                    if (last_col) begin
                        col <= '0;
                        if (nb >= RW'(NUM_ROWS)) begin
                            row_base <= '0;
                            state    <= DRAIN;
                        end else begin
                            row_base <= nb;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DRAIN: if (drained) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
                DONE:    state <= ACTIVE;
                default: state <= ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v0 <= 1'b0;
            s1_v1 <= 1'b0;
            s1_a0 <= '0;
            s1_a1 <= '0;
            s1_d0 <= '0;
            s1_d1 <= '0;
        end else if (clear) begin
            s1_v0 <= 1'b0;
            s1_v1 <= 1'b0;
            s1_a0 <= '0;
            s1_a1 <= '0;
            s1_d0 <= '0;
            s1_d1 <= '0;
        end else begin
            s1_v0 <= accept;
            s1_v1 <= accept && in1_valid;
            s1_a0 <= a0;
            s1_a1 <= a0 + ADDR_W'(ROW_LEN);
            s1_d0 <= requant(in0, bias, relu_en);
            s1_d1 <= requant(in1, bias, relu_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push0) fifo_mem[wr_ptr] <= {s1_a0, s1_d0};
        if (push1) fifo_mem[push0 ? wr_ptr + 1'b1 : wr_ptr] <= {s1_a1, s1_d1};
    end

    // An empty queue lets lane 0 bypass straight into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else if (clear) begin
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            cnt    <= cnt + (PW+1)'(push0) + (PW+1)'(push1) - (PW+1)'(from_fifo);
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            if (from_fifo) rd_ptr <= rd_ptr + 1'b1;
            if (take) begin
                mem_wr_en <= from_fifo || bypass;
                if (from_fifo) begin
                    {mem_wr_addr, mem_wr_data} <= fifo_mem[rd_ptr];
                end else if (bypass) begin
                    mem_wr_addr <= s1_a0;
                    mem_wr_data <= s1_d0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            overflow  <= overflow | drop | (in0_valid && state != ACTIVE);
            proto_err <= proto_err | (in1_valid && !in0_valid);
        end
    end
endmodule
